spu32_cpu_mulctrl: RTL and testbench



---
 rtl/spu32_cpu_mulctrl_pkg.sv | 37 +++
 rtl/spu32_cpu_mulpipe.sv | 44 ++++
 rtl/spu32_cpu_mulctrl.sv | 172 +++++++++++++++++
 tb/tb_spu32_cpu_mulctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spu32_cpu_mulctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spu32_cpu_mulctrl_pkg
// Brief    : Shared encodings for the M-extension multiply controller.
//            Holds the FSM state codes, the multiply opcodes and the
//            op -> operand signedness decode.
// Revision : 1.0 - initial release
// ============================================================================
package spu32_cpu_mulctrl_pkg;

    // ALU opcodes of the multiply group; values match the CPU's ALU opcode table
    localparam logic [3:0] c_aluop_mul    = 4'hA;
    localparam logic [3:0] c_aluop_mulh   = 4'hB;
    localparam logic [3:0] c_aluop_mulhsu = 4'hC;
    localparam logic [3:0] c_aluop_mulhu  = 4'hD;

    // Controller state encoding
    localparam int         c_state_w    = 2;
    localparam logic [1:0] c_state_idle = 2'd0;
    localparam logic [1:0] c_state_busy = 2'd1;
    localparam logic [1:0] c_state_done = 2'd2;

    // Returns {s1_signed, s2_signed}; MUL and MULHU treat both operands as unsigned
    function automatic logic [1:0] f_op_signedness(input logic [3:0] op);
        logic [1:0] sgn;
        sgn = 2'b00;
        case (op)
            c_aluop_mulh:   sgn = 2'b11;
            c_aluop_mulhsu: sgn = 2'b10;
            default:        sgn = 2'b00;
        endcase
        return sgn;
    endfunction

endpackage : spu32_cpu_mulctrl_pkg
`default_nettype wire

// File: rtl/spu32_cpu_mulpipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spu32_cpu_mulpipe
// Brief    : 33x33 signed multiplier keeping the low 64 product bits,
//            followed by LATENCY register stages sharing one clock enable.
// Revision : 1.0 - initial release
// ============================================================================
module spu32_cpu_mulpipe #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        i_ce,
    input  logic [32:0] i_a,
    input  logic [32:0] i_b,
    output logic [63:0] o_p
);

    // Sign-extending both 33-bit operands to 64 bits makes a plain 64-bit
    // multiply produce the exact signed product modulo 2^64.
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;

    assign w_a64  = {{31{i_a[32]}}, i_a};
    assign w_b64  = {{31{i_b[32]}}, i_b};
    assign w_prod = w_a64 * w_b64;

    logic [63:0] r_stage_q [LATENCY];

    // Product pipeline; pure datapath, so no reset is needed
    always_ff @(posedge clk) begin
        if (i_ce) begin
            r_stage_q[0] <= w_prod;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage_q[i] <= r_stage_q[i-1];
            end
        end
    end

    assign o_p = r_stage_q[LATENCY-1];

endmodule : spu32_cpu_mulpipe
`default_nettype wire

// File: rtl/spu32_cpu_mulctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spu32_cpu_mulctrl
// Brief    : Multiply sequencer: accepts one request, drives the pipelined
//            multiplier, returns the selected word with busy/done handshake,
//            and short-circuits repeats through a one-entry product cache.
// Revision : 1.0 - initial release
// ============================================================================
module spu32_cpu_mulctrl
    import spu32_cpu_mulctrl_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_en,
    input  logic [3:0]  I_op,
    input  logic [31:0] I_s1,
    input  logic [31:0] I_s2,
    output logic [31:0] O_result,
    output logic        O_busy,
    output logic        O_done
);

    localparam logic [1:0] c_cnt_init = 2'(LATENCY - 1);

    logic [c_state_w-1:0] r_state_q, w_state_d;
    logic [1:0]  r_cnt_q,   w_cnt_d;
    logic [31:0] r_s1_q,    w_s1_d;
    logic [31:0] r_s2_q,    w_s2_d;
    logic [3:0]  r_op_q,    w_op_d;
    logic [31:0] r_result_q, w_result_d;
    // Product cache entry
    logic        r_cv_q,    w_cv_d;
    logic [31:0] r_cs1_q,   w_cs1_d;
    logic [31:0] r_cs2_q,   w_cs2_d;
    logic [1:0]  r_csgn_q,  w_csgn_d;
    logic [63:0] r_cprod_q, w_cprod_d;

    logic        w_accept, w_hit, w_launch, w_finish, w_ce;
    logic [1:0]  w_req_sgn, w_src_sgn;
    logic [31:0] w_src_s1, w_src_s2;
    logic [63:0] w_prod;

    assign w_accept  = ((r_state_q == c_state_idle) || (r_state_q == c_state_done)) && I_en;
    assign w_req_sgn = f_op_signedness(I_op);
    // The low word is signedness-independent, so MUL ignores the stored signedness
    assign w_hit     = r_cv_q && (I_s1 == r_cs1_q) && (I_s2 == r_cs2_q) &&
                       ((I_op == c_aluop_mul) || (w_req_sgn == r_csgn_q));
    assign w_launch  = w_accept && !w_hit;
    assign w_finish  = (r_state_q == c_state_busy) && (r_cnt_q == 2'd0);

    // Launch from the live request; while busy keep feeding the latched operands
    assign w_src_s1  = w_accept ? I_s1 : r_s1_q;
    assign w_src_s2  = w_accept ? I_s2 : r_s2_q;
    assign w_src_sgn = w_accept ? w_req_sgn : f_op_signedness(r_op_q);
    assign w_ce      = w_launch || (r_state_q == c_state_busy);

    spu32_cpu_mulpipe #(
        .LATENCY (LATENCY)
    ) u_mulpipe (
        .clk  (I_clk),
        .i_ce (w_ce),
        .i_a  ({w_src_sgn[1] & w_src_s1[31], w_src_s1}),
        .i_b  ({w_src_sgn[0] & w_src_s2[31], w_src_s2}),
        .o_p  (w_prod)
    );

    // State register
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_state_q <= c_state_idle;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Next-state logic: hits skip straight to DONE, misses wait out the pipeline
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_state_idle, c_state_done: begin
                if (I_en) begin
                    w_state_d = w_hit ? c_state_done : c_state_busy;
                end else begin
                    w_state_d = c_state_idle;
                end
            end
            c_state_busy: begin
                if (r_cnt_q == 2'd0) begin
                    w_state_d = c_state_done;
                end
            end
            default: w_state_d = c_state_idle;
        endcase
    end

    // Handshake outputs decoded from the registered state
    always_comb begin
        O_busy = (r_state_q == c_state_busy);
        O_done = (r_state_q == c_state_done);
    end

    // Datapath next values: operand latch, counter, cache fill, result select
    always_comb begin
        w_cnt_d    = r_cnt_q;
        w_s1_d     = r_s1_q;
        w_s2_d     = r_s2_q;
        w_op_d     = r_op_q;
        w_result_d = r_result_q;
        w_cv_d     = r_cv_q;
        w_cs1_d    = r_cs1_q;
        w_cs2_d    = r_cs2_q;
        w_csgn_d   = r_csgn_q;
        w_cprod_d  = r_cprod_q;
        if (w_accept) begin
            w_s1_d = I_s1;
            w_s2_d = I_s2;
            w_op_d = I_op;
            if (w_hit) begin
                w_result_d = (I_op == c_aluop_mul) ? r_cprod_q[31:0] : r_cprod_q[63:32];
            end else begin
                w_cnt_d = c_cnt_init;
            end
        end
        if (r_state_q == c_state_busy) begin
            if (r_cnt_q != 2'd0) begin
                w_cnt_d = r_cnt_q - 2'd1;
            end
        end
        if (w_finish) begin
            w_cv_d     = 1'b1;
            w_cs1_d    = r_s1_q;
            w_cs2_d    = r_s2_q;
            w_csgn_d   = f_op_signedness(r_op_q);
            w_cprod_d  = w_prod;
            w_result_d = (r_op_q == c_aluop_mul) ? w_prod[31:0] : w_prod[63:32];
        end
    end

    // Datapath registers; reset also invalidates the cache
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_cnt_q    <= 2'd0;
            r_s1_q     <= 32'd0;
            r_s2_q     <= 32'd0;
            r_op_q     <= 4'd0;
            r_result_q <= 32'd0;
            r_cv_q     <= 1'b0;
            r_cs1_q    <= 32'd0;
            r_cs2_q    <= 32'd0;
            r_csgn_q   <= 2'b00;
            r_cprod_q  <= 64'd0;
        end else begin
            r_cnt_q    <= w_cnt_d;
            r_s1_q     <= w_s1_d;
            r_s2_q     <= w_s2_d;
            r_op_q     <= w_op_d;
            r_result_q <= w_result_d;
            r_cv_q     <= w_cv_d;
            r_cs1_q    <= w_cs1_d;
            r_cs2_q    <= w_cs2_d;
            r_csgn_q   <= w_csgn_d;
            r_cprod_q  <= w_cprod_d;
        end
    end

    assign O_result = r_result_q;

endmodule : spu32_cpu_mulctrl
`default_nettype wire

// File: tb/tb_spu32_cpu_mulctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spu32_cpu_mulctrl
// Brief    : Self-checking bench for the multiply controller: directed
//            vectors, cache/back-to-back/reset sequences and random requests
//            against an arithmetic reference model with a cache model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spu32_cpu_mulctrl;
    import spu32_cpu_mulctrl_pkg::*;

    localparam int LATENCY = 2;

    logic        I_clk = 1'b0;
    logic        I_reset = 1'b1;
    logic        I_en = 1'b0;
    logic [3:0]  I_op = 4'd0;
    logic [31:0] I_s1 = 32'd0;
    logic [31:0] I_s2 = 32'd0;
    logic [31:0] O_result;
    logic        O_busy;
    logic        O_done;

    spu32_cpu_mulctrl #(.LATENCY(LATENCY)) dut (
        .I_clk    (I_clk),
        .I_reset  (I_reset),
        .I_en     (I_en),
        .I_op     (I_op),
        .I_s1     (I_s1),
        .I_s2     (I_s2),
        .O_result (O_result),
        .O_busy   (O_busy),
        .O_done   (O_done)
    );

    always #5 I_clk = ~I_clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: extend each operand to a 64-bit integer by the op's rule, multiply
    function automatic logic [31:0] ref_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        logic [63:0] p;
        x = (op == c_aluop_mulh || op == c_aluop_mulhsu) ? longint'(int'(a)) : longint'({32'd0, a});
        y = (op == c_aluop_mulh) ? longint'(int'(b)) : longint'({32'd0, b});
        p = 64'(x * y);
        return (op == c_aluop_mul) ? p[31:0] : p[63:32];
    endfunction

    // Cache model: last completed multiplier run
    bit          mc_valid = 1'b0;
    logic [31:0] mc_a, mc_b;
    bit          mc_sa, mc_sb;

    function automatic bit model_hit(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit sa, sb;
        sa = (op == c_aluop_mulh || op == c_aluop_mulhsu);
        sb = (op == c_aluop_mulh);
        return mc_valid && a == mc_a && b == mc_b &&
               (op == c_aluop_mul || (sa == mc_sa && sb == mc_sb));
    endfunction

    // Issue a request at the current point (between edges); returns in the DONE cycle
    task automatic run_req(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input bit exp_hit,
                           input bit poke);
        int busy_n;
        int done_at;
        busy_n  = 0;
        done_at = 0;
        I_en = 1'b1; I_op = op; I_s1 = a; I_s2 = b;
        @(posedge I_clk); #1;
        // scramble inputs after accept: must not matter
        I_en = 1'b0; I_op = 4'($urandom); I_s1 = ~a; I_s2 = b ^ 32'h5A5A_A5A5;
        for (int cyc = 1; cyc <= 12 && done_at == 0; cyc++) begin
            @(negedge I_clk);
            if (O_busy && O_done) check({name, "_busy_and_done"}, 1, 0);
            if (O_busy) busy_n++;
            if (O_done) done_at = cyc;
            if (poke && cyc == 1) begin
                I_en = 1'b1; I_op = c_aluop_mulhu; I_s1 = $urandom; I_s2 = $urandom;
            end else begin
                I_en = 1'b0;
            end
        end
        check({name, "_done_cycle"}, done_at, exp_hit ? 1 : LATENCY + 1);
        check({name, "_busy_cycles"}, busy_n, exp_hit ? 0 : LATENCY);
        check({name, "_result"}, O_result, exp);
        if (!exp_hit) begin
            mc_valid = 1'b1; mc_a = a; mc_b = b;
            mc_sa = (op == c_aluop_mulh || op == c_aluop_mulhsu);
            mc_sb = (op == c_aluop_mulh);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] exp;
        bit          hit;
        bit          b2b;
    } vec_t;

    vec_t tbl[11];

    initial begin : main
        logic [3:0]  ops[4];
        logic [31:0] corners[5];
        logic [31:0] ra, rb, rexp, last;
        logic [3:0]  rop;
        int          extra;
        bit          h;

        ops = '{c_aluop_mul, c_aluop_mulh, c_aluop_mulhsu, c_aluop_mulhu};
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        tbl[0]  = '{c_aluop_mul,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 0};
        tbl[1]  = '{c_aluop_mul,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0};
        tbl[2]  = '{c_aluop_mulh,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1};
        tbl[3]  = '{c_aluop_mulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0};
        tbl[4]  = '{c_aluop_mulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1};
        tbl[5]  = '{c_aluop_mulhu,  32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 0, 0};
        tbl[6]  = '{c_aluop_mulh,   32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 0, 1};
        tbl[7]  = '{c_aluop_mulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 0};
        tbl[8]  = '{c_aluop_mulhsu, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 0, 1};
        tbl[9]  = '{c_aluop_mul,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 1};
        tbl[10] = '{c_aluop_mulhu,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 0};

        // Reset state
        repeat (3) @(negedge I_clk);
        I_reset = 1'b0;
        @(negedge I_clk);
        check("reset_busy", O_busy, 0);
        check("reset_done", O_done, 0);
        check("reset_result", O_result, 0);

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            if (!tbl[i].b2b) begin
                @(negedge I_clk);
                if (i > 0) check($sformatf("vec%0d_hold", i), O_result, tbl[i-1].exp);
            end
            run_req($sformatf("vec%0d", i), tbl[i].op, tbl[i].s1, tbl[i].s2, tbl[i].exp, tbl[i].hit, 0);
        end

        // MULH then MUL on same operands back-to-back: second one is a cache hit
        @(negedge I_clk);
        run_req("hit_mulh", c_aluop_mulh, 32'h1234_5678, 32'h9ABC_DEF0,
                ref_mul(c_aluop_mulh, 32'h1234_5678, 32'h9ABC_DEF0), 0, 0);
        run_req("hit_mul", c_aluop_mul, 32'h1234_5678, 32'h9ABC_DEF0,
                ref_mul(c_aluop_mul, 32'h1234_5678, 32'h9ABC_DEF0), 1, 0);

        // Request pulsed mid-BUSY is ignored; exactly one done pulse
        @(negedge I_clk);
        run_req("poke", c_aluop_mulhsu, 32'hDEAD_BEEF, 32'hCAFE_F00D,
                ref_mul(c_aluop_mulhsu, 32'hDEAD_BEEF, 32'hCAFE_F00D), 0, 1);
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge I_clk);
            if (O_done) extra++;
        end
        check("poke_extra_done", extra, 0);
        check("poke_result_hold", O_result, ref_mul(c_aluop_mulhsu, 32'hDEAD_BEEF, 32'hCAFE_F00D));

        // Reset on the first BUSY cycle
        I_en = 1'b1; I_op = c_aluop_mulh; I_s1 = 32'h0BAD_F00D; I_s2 = 32'h7654_3210;
        @(posedge I_clk); #1;
        I_en = 1'b0;
        @(negedge I_clk);
        check("rst_busy_before", O_busy, 1);
        I_reset = 1'b1;
        @(negedge I_clk);
        I_reset = 1'b0;
        check("rst_busy_after", O_busy, 0);
        check("rst_done_after", O_done, 0);
        check("rst_result_after", O_result, 0);
        mc_valid = 1'b0;
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge I_clk);
            if (O_done) extra++;
        end
        check("rst_late_done", extra, 0);
        run_req("rst_repeat", c_aluop_mulh, 32'h0BAD_F00D, 32'h7654_3210,
                ref_mul(c_aluop_mulh, 32'h0BAD_F00D, 32'h7654_3210), 0, 0);
        last = ref_mul(c_aluop_mulh, 32'h0BAD_F00D, 32'h7654_3210);

        // Random requests against the model; operand reuse exercises the cache
        ra = 32'h1; rb = 32'h1;
        for (int i = 0; i < 40; i++) begin
            rop = ops[$urandom_range(0, 3)];
            case ($urandom_range(0, 3))
                0: ; // reuse previous operands
                1: begin ra = corners[$urandom_range(0, 4)]; rb = corners[$urandom_range(0, 4)]; end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            if ($urandom_range(0, 1) == 0) begin
                @(negedge I_clk);
                check($sformatf("rnd%0d_hold", i), O_result, last);
            end
            rexp = ref_mul(rop, ra, rb);
            h = model_hit(rop, ra, rb);
            run_req($sformatf("rnd%0d", i), rop, ra, rb, rexp, h, 0);
            last = rexp;
        end

        @(negedge I_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule : tb_spu32_cpu_mulctrl
`default_nettype wire
